pipeline_stall_controller: RTL and testbench

Central hazard and stall sequencer for the five-stage RISC-V pipeline. It combines instruction-cache misses, data-cache misses, load-use hazards and branch/jump redirects from the program-counter stage into one consistent set of per-stage stall and clear strobes. It also tracks a fetch squashed by a redirect during an outstanding instruction-cache miss. Two wrap-around performance counters are exposed.

---
 rtl/pipeline_stall_controller.sv | 133 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard and stall sequencer for the five-stage pipeline: merges cache misses, load-use
// hazards and redirects into per-stage stall/clear strobes, plus two wrap-around counters.
module pipeline_stall_controller #(
    parameter int STALL_COUNT_WIDTH = 32,
    parameter int FLUSH_COUNT_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         INSTRUCTION_CACHE_READY,
    input  logic                         DATA_CACHE_REQUEST,
    input  logic                         DATA_CACHE_READY,
    input  logic                         REDIRECT,
    input  logic                         LOAD_IN_EXECUTION,
    input  logic [4:0]                   RD_EXECUTION,
    input  logic [4:0]                   RS1_DECODING,
    input  logic [4:0]                   RS2_DECODING,
    input  logic                         RS1_USED,
    input  logic                         RS2_USED,
    output logic                         STALL_PROGRAME_COUNTER_STAGE,
    output logic                         STALL_INSTRUCTION_FETCH_STAGE,
    output logic                         STALL_DECODING_STAGE,
    output logic                         STALL_EXECUTION_STAGE,
    output logic                         STALL_MEMORY_STAGE,
    output logic                         CLEAR_INSTRUCTION_FETCH_STAGE,
    output logic                         CLEAR_DECODING_STAGE,
    output logic                         CLEAR_EXECUTION_STAGE,
    output logic [STALL_COUNT_WIDTH-1:0] STALL_CYCLE_COUNT,
    output logic [FLUSH_COUNT_WIDTH-1:0] FLUSH_COUNT,
    output logic                         DEBUG_STATE
);

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t state;
    state_t next_state;
    logic   dmiss;
    logic   imiss;
    logic   lu;
    logic   flush_take;

    assign dmiss = DATA_CACHE_REQUEST & ~DATA_CACHE_READY;
    assign imiss = ~INSTRUCTION_CACHE_READY;
    assign lu    = LOAD_IN_EXECUTION && (RD_EXECUTION != 5'd0) &&
                   ((RS1_USED && (RS1_DECODING == RD_EXECUTION)) ||
                    (RS2_USED && (RS2_DECODING == RD_EXECUTION)));

    assign DEBUG_STATE = state;

    always_comb begin
        STALL_PROGRAME_COUNTER_STAGE  = LOW;
        STALL_INSTRUCTION_FETCH_STAGE = LOW;
        STALL_DECODING_STAGE          = LOW;
        STALL_EXECUTION_STAGE         = LOW;
        STALL_MEMORY_STAGE            = LOW;
        CLEAR_INSTRUCTION_FETCH_STAGE = LOW;
        CLEAR_DECODING_STAGE          = LOW;
        CLEAR_EXECUTION_STAGE         = LOW;
        flush_take                    = LOW;
        next_state                    = state;

        if (RST) begin
            STALL_PROGRAME_COUNTER_STAGE  = HIGH;
            STALL_INSTRUCTION_FETCH_STAGE = HIGH;
            STALL_DECODING_STAGE          = HIGH;
            STALL_EXECUTION_STAGE         = HIGH;
            STALL_MEMORY_STAGE            = HIGH;
            CLEAR_INSTRUCTION_FETCH_STAGE = HIGH;
            CLEAR_DECODING_STAGE          = HIGH;
            CLEAR_EXECUTION_STAGE         = HIGH;
            next_state                    = RUN;
        end else if (dmiss) begin
            // Whole pipe frozen; a pending redirect is held by the PC stage until dmiss drops.
            STALL_PROGRAME_COUNTER_STAGE  = HIGH;
            STALL_INSTRUCTION_FETCH_STAGE = HIGH;
            STALL_DECODING_STAGE          = HIGH;
            STALL_EXECUTION_STAGE         = HIGH;
            STALL_MEMORY_STAGE            = HIGH;
        end else if (REDIRECT) begin
            CLEAR_INSTRUCTION_FETCH_STAGE = HIGH;
            CLEAR_DECODING_STAGE          = HIGH;
            flush_take                    = HIGH;
            next_state                    = imiss ? SQUASH : RUN;
        end else if (state == SQUASH) begin
            // The returning fetch belongs to the squashed path; IF is cleared rather than held.
            STALL_PROGRAME_COUNTER_STAGE = HIGH;
            CLEAR_DECODING_STAGE         = HIGH;
            if (INSTRUCTION_CACHE_READY) begin
                CLEAR_INSTRUCTION_FETCH_STAGE = HIGH;
                next_state                    = RUN;
            end else begin
                STALL_INSTRUCTION_FETCH_STAGE = HIGH;
            end
        end else if (lu) begin
            STALL_PROGRAME_COUNTER_STAGE  = HIGH;
            STALL_INSTRUCTION_FETCH_STAGE = HIGH;
            STALL_DECODING_STAGE          = HIGH;
            CLEAR_EXECUTION_STAGE         = HIGH;
        end else if (imiss) begin
            STALL_PROGRAME_COUNTER_STAGE  = HIGH;
            STALL_INSTRUCTION_FETCH_STAGE = HIGH;
            CLEAR_DECODING_STAGE          = HIGH;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CYCLE_COUNT <= '0;
            FLUSH_COUNT       <= '0;
        end else begin
            if (STALL_PROGRAME_COUNTER_STAGE) begin
                STALL_CYCLE_COUNT <= STALL_CYCLE_COUNT + 1'b1;
            end
            if (flush_take) begin
                FLUSH_COUNT <= FLUSH_COUNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; outputs are packed as
// {stall pc,if,id,ex,mem, clear if,id,ex} and compared against hand-computed codes.
module tb_pipeline_stall_controller;

    logic        clk;
    logic        rst;
    logic        ic_ready;
    logic        dc_req;
    logic        dc_ready;
    logic        redirect;
    logic        load_ex;
    logic [4:0]  rd_ex;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rs1_used;
    logic        rs2_used;
    logic        s_pc, s_if, s_id, s_ex, s_mem;
    logic        c_if, c_id, c_ex;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] O_NONE   = 8'h00;
    localparam logic [7:0] O_RST    = 8'hFF;
    localparam logic [7:0] O_LU     = 8'hE1;
    localparam logic [7:0] O_IMISS  = 8'hC2;
    localparam logic [7:0] O_REDIR  = 8'h06;
    localparam logic [7:0] O_SQ_RDY = 8'h86;
    localparam logic [7:0] O_DMISS  = 8'hF8;

    pipeline_stall_controller dut (
        .CLK                           (clk),
        .RST                           (rst),
        .INSTRUCTION_CACHE_READY       (ic_ready),
        .DATA_CACHE_REQUEST            (dc_req),
        .DATA_CACHE_READY              (dc_ready),
        .REDIRECT                      (redirect),
        .LOAD_IN_EXECUTION             (load_ex),
        .RD_EXECUTION                  (rd_ex),
        .RS1_DECODING                  (rs1_id),
        .RS2_DECODING                  (rs2_id),
        .RS1_USED                      (rs1_used),
        .RS2_USED                      (rs2_used),
        .STALL_PROGRAME_COUNTER_STAGE  (s_pc),
        .STALL_INSTRUCTION_FETCH_STAGE (s_if),
        .STALL_DECODING_STAGE          (s_id),
        .STALL_EXECUTION_STAGE         (s_ex),
        .STALL_MEMORY_STAGE            (s_mem),
        .CLEAR_INSTRUCTION_FETCH_STAGE (c_if),
        .CLEAR_DECODING_STAGE          (c_id),
        .CLEAR_EXECUTION_STAGE         (c_ex),
        .STALL_CYCLE_COUNT             (stall_cnt),
        .FLUSH_COUNT                   (flush_cnt),
        .DEBUG_STATE                   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {s_pc, s_if, s_id, s_ex, s_mem, c_if, c_id, c_ex};
    endfunction

    // Advance one edge, then let inputs be driven / outputs be sampled mid-cycle.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        ic_ready = 1'b1; dc_req = 1'b0; dc_ready = 1'b1; redirect = 1'b0;
        load_ex = 1'b0; rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        // Reset: two cycles of RST
        for (int i = 0; i < 2; i++) begin
            #1 check($sformatf("rst_outs_%0d", i), {24'd0, outs()}, {24'd0, O_RST});
            cycle();
        end
        rst = 1'b0;
        #1;
        check("post_rst_outs", {24'd0, outs()}, {24'd0, O_NONE});
        check("post_rst_state", {31'd0, dbg_state}, 32'd0);
        check("post_rst_stall_cnt", stall_cnt, 32'd0);
        check("post_rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);

        // Load-use on RS2 for one cycle
        load_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs2_used = 1'b1;
        #1 check("lu_outs", {24'd0, outs()}, {24'd0, O_LU});
        cycle();
        idle_inputs();
        #1 check("lu_after_outs", {24'd0, outs()}, {24'd0, O_NONE});
        check("lu_stall_cnt", stall_cnt, 32'd1);

        // Load to x0 is not a hazard
        load_ex = 1'b1; rd_ex = 5'd0; rs2_id = 5'd0; rs2_used = 1'b1; rs1_used = 1'b1;
        #1 check("lu_x0_outs", {24'd0, outs()}, {24'd0, O_NONE});
        cycle();
        idle_inputs();
        check("lu_x0_stall_cnt", stall_cnt, 32'd1);

        // I-miss for three cycles
        ic_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("imiss_outs_%0d", i), {24'd0, outs()}, {24'd0, O_IMISS});
            check($sformatf("imiss_state_%0d", i), {31'd0, dbg_state}, 32'd0);
            cycle();
        end
        ic_ready = 1'b1;
        #1 check("imiss_done_outs", {24'd0, outs()}, {24'd0, O_NONE});
        check("imiss_stall_cnt", stall_cnt, 32'd4);
        check("imiss_state", {31'd0, dbg_state}, 32'd0);

        // Redirect during I-miss, ready returns two cycles later
        redirect = 1'b1; ic_ready = 1'b0;
        #1 check("sq_redir_outs", {24'd0, outs()}, {24'd0, O_REDIR});
        cycle();
        redirect = 1'b0;
        check("sq_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check("sq_state", {31'd0, dbg_state}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            #1 check($sformatf("sq_wait_outs_%0d", i), {24'd0, outs()}, {24'd0, O_IMISS});
            cycle();
        end
        ic_ready = 1'b1;
        #1 check("sq_ready_outs", {24'd0, outs()}, {24'd0, O_SQ_RDY});
        check("sq_ready_state", {31'd0, dbg_state}, 32'd1);
        cycle();
        #1 check("sq_exit_outs", {24'd0, outs()}, {24'd0, O_NONE});
        check("sq_exit_state", {31'd0, dbg_state}, 32'd0);
        check("sq_stall_cnt", stall_cnt, 32'd7);

        // D-miss for four cycles with redirect pending
        dc_req = 1'b1; dc_ready = 1'b0; redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("dmiss_outs_%0d", i), {24'd0, outs()}, {24'd0, O_DMISS});
            cycle();
            check($sformatf("dmiss_flush_%0d", i), {16'd0, flush_cnt}, 32'd1);
        end
        dc_ready = 1'b1;
        #1 check("dmiss_redir_outs", {24'd0, outs()}, {24'd0, O_REDIR});
        cycle();
        idle_inputs();
        check("dmiss_redir_flush", {16'd0, flush_cnt}, 32'd2);
        check("dmiss_stall_cnt", stall_cnt, 32'd11);

        // D-miss inside SQUASH keeps the state
        redirect = 1'b1; ic_ready = 1'b0;
        cycle();
        redirect = 1'b0; dc_req = 1'b1; dc_ready = 1'b0;
        #1 check("sq_dmiss_outs", {24'd0, outs()}, {24'd0, O_DMISS});
        cycle();
        check("sq_dmiss_state", {31'd0, dbg_state}, 32'd1);
        check("sq_dmiss_flush", {16'd0, flush_cnt}, 32'd3);

        // Reset in the middle of SQUASH
        dc_req = 1'b0; dc_ready = 1'b1; rst = 1'b1;
        #1 check("mid_rst_outs", {24'd0, outs()}, {24'd0, O_RST});
        cycle();
        rst = 1'b0; ic_ready = 1'b1;
        #1 check("mid_rst_after_outs", {24'd0, outs()}, {24'd0, O_NONE});
        check("mid_rst_state", {31'd0, dbg_state}, 32'd0);
        check("mid_rst_stall_cnt", stall_cnt, 32'd0);
        check("mid_rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);

        // Flush counter wraps after 65536 redirects
        redirect = 1'b1;
        for (int i = 0; i < 65536; i++) cycle();
        check("wrap_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check("wrap_stall_cnt", stall_cnt, 32'd0);

        // Redirect outranks load-use
        load_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; rs1_used = 1'b1;
        #1 check("redir_lu_outs", {24'd0, outs()}, {24'd0, O_REDIR});
        cycle();
        idle_inputs();
        check("redir_lu_flush", {16'd0, flush_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
